// File: rtl/life_pkg.sv
// life_pkg: shared FSM state encoding and strobe decode for the life sequencer.
//   Contents: state_t (IDLE/LOAD/COMPUTE/STORE/NEXT), strobes_t, decode().
package life_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        STORE   = 3'd3,
        NEXT    = 3'd4
    } state_t;

    typedef struct packed {
        logic write_array;
        logic run;
        logic write_mem;
        logic busy;
    } strobes_t;

    // Every strobe is a pure function of the state register, so an
    // asynchronous reset of the state clears them with no clock edge.
    function automatic strobes_t decode(input state_t s);
        return '{write_array: s == LOAD,
                 run:         s == COMPUTE,
                 write_mem:   s == STORE,
                 busy:        s != IDLE};
    endfunction

endpackage

// File: rtl/life_row_counter.sv
// life_row_counter: row index register with increment, clear and last-row flag.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_inc        : advance to the next row
//   i_clr        : return to row 0 (wins over i_inc)
//   o_row        : current row index
//   o_last       : current row is ROWS-1
module life_row_counter #(
    parameter int ROWS  = 16,
    parameter int ROW_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [ROW_W-1:0] o_row,
    output logic             o_last
);

    logic [ROW_W-1:0] r_row;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_row <= '0;
        else
            r_row <= i_clr ? '0 : (i_inc ? r_row + ROW_W'(1) : r_row);
    end

    assign o_row  = r_row;
    assign o_last = r_row == ROW_W'(ROWS - 1);

endmodule

// File: rtl/life_sequencer.sv
// life_sequencer: sweeps board rows through load/compute/store once per generation.
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   i_start/i_stop  : arm/disarm continuous mode (stop wins)
//   i_step          : run one generation from IDLE
//   i_frame_tick    : starts a generation from IDLE when continuous mode is armed
//   i_mem_ready     : memory accepts the row write; STORE holds until it is high
//   o_row           : row being processed
//   o_write_array, o_run, o_write_mem : per-state strobes (LOAD, COMPUTE, STORE)
//   o_busy          : generation in progress
//   o_continuous    : continuous mode armed
//   o_gen_done      : one-cycle pulse in the final NEXT of a generation
//   o_gen_count     : completed generations, wrapping
module life_sequencer
    import life_pkg::*;
#(
    parameter int ROWS  = 16,
    parameter int ROW_W = 4,
    parameter int GEN_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_step,
    input  logic             i_frame_tick,
    input  logic             i_mem_ready,
    output logic [ROW_W-1:0] o_row,
    output logic             o_write_array,
    output logic             o_run,
    output logic             o_write_mem,
    output logic             o_busy,
    output logic             o_continuous,
    output logic             o_gen_done,
    output logic [GEN_W-1:0] o_gen_count
);

    state_t           r_state;
    logic [GEN_W-1:0] r_gen_count;
    logic             r_continuous;
    logic             w_last;
    logic             w_next;
    strobes_t         w_strobes;

    assign w_next    = r_state == NEXT;
    assign w_strobes = decode(r_state);

    life_row_counter #(.ROWS(ROWS), .ROW_W(ROW_W)) u_row (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_inc  (w_next && !w_last),
        .i_clr  (w_next && w_last),
        .o_row  (o_row),
        .o_last (w_last)
    );

    // Requests are honoured only in IDLE, so step/frame_tick while busy are
    // dropped rather than queued, and stop never aborts a running generation.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_gen_count  <= '0;
            r_continuous <= 1'b0;
        end else begin
            r_continuous <= i_stop ? 1'b0 : (i_start ? 1'b1 : r_continuous);
            case (r_state)
                IDLE:    if (i_step || (r_continuous && i_frame_tick)) r_state <= LOAD;
                LOAD:    r_state <= COMPUTE;
                COMPUTE: r_state <= STORE;
                STORE:   if (i_mem_ready) r_state <= NEXT;
                NEXT: begin
                    r_state <= w_last ? IDLE : LOAD;
                    if (w_last) r_gen_count <= r_gen_count + GEN_W'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_write_array = w_strobes.write_array;
    assign o_run         = w_strobes.run;
    assign o_write_mem   = w_strobes.write_mem;
    assign o_busy        = w_strobes.busy;
    assign o_continuous  = r_continuous;
    assign o_gen_done    = w_next && w_last;
    assign o_gen_count   = r_gen_count;

endmodule

// File: tb/tb_life_sequencer.sv
// tb_life_sequencer: directed and randomized checks of life_sequencer against a trace model.
module tb_life_sequencer;

    localparam int ROWS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, step = 1'b0, frame_tick = 1'b0, mem_ready = 1'b1;
    logic [3:0]  row;
    logic        write_array, run, write_mem, busy, continuous, gen_done;
    logic [15:0] gen_count;

    logic        step2 = 1'b0;
    logic        row2;
    logic        wa2, rn2, wm2, busy2, cont2, gd2;
    logic [3:0]  gc2;

    int n_chk = 0;
    int n_fail = 0;
    int gc = 0;
    bit cont = 1'b0;
    int st[ROWS];

    // v = {write_array, run, write_mem, busy, gen_done, row}
    typedef struct {
        logic [8:0] v;
        bit         mr;
        bit         ld;
    } ent_t;

    always #5 clk = ~clk;

    life_sequencer #(.ROWS(ROWS), .ROW_W(4), .GEN_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_step(step),
        .i_frame_tick(frame_tick), .i_mem_ready(mem_ready), .o_row(row),
        .o_write_array(write_array), .o_run(run), .o_write_mem(write_mem),
        .o_busy(busy), .o_continuous(continuous), .o_gen_done(gen_done),
        .o_gen_count(gen_count)
    );

    life_sequencer #(.ROWS(2), .ROW_W(1), .GEN_W(4)) u2 (
        .i_clk(clk), .i_rst(rst), .i_start(1'b0), .i_stop(1'b0), .i_step(step2),
        .i_frame_tick(1'b0), .i_mem_ready(1'b1), .o_row(row2),
        .o_write_array(wa2), .o_run(rn2), .o_write_mem(wm2),
        .o_busy(busy2), .o_continuous(cont2), .o_gen_done(gd2),
        .o_gen_count(gc2)
    );

    function automatic logic [8:0] obs_v();
        return {write_array, run, write_mem, busy, gen_done, row};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "/strobes"}, 32'(obs_v()), 32'h0);
        chk({tag, "/gen_count"}, 32'(gen_count), gc);
        chk({tag, "/continuous"}, 32'(continuous), 32'(cont));
    endtask

    task automatic idle(input int n, input string tag, input bit tick);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_idle(tag);
            start = 1'b0; stop = 1'b0; step = 1'b0; frame_tick = tick; mem_ready = 1'b1;
        end
    endtask

    // Expected per-cycle trace of one generation: each row is LOAD, COMPUTE,
    // STORE held for st[r] stall cycles plus the accepting cycle, then NEXT.
    task automatic run_gen(input bit use_step, input bit use_tick, input bit noise,
                           input int stop_row, input int abort_row, input string tag);
        ent_t q[$];
        for (int r = 0; r < ROWS; r++) begin
            q.push_back('{v: {4'b1001, 1'b0, 4'(r)}, mr: 1'b1, ld: 1'b1});
            q.push_back('{v: {4'b0101, 1'b0, 4'(r)}, mr: 1'b1, ld: 1'b0});
            for (int s = 0; s < st[r]; s++)
                q.push_back('{v: {4'b0011, 1'b0, 4'(r)}, mr: 1'b0, ld: 1'b0});
            q.push_back('{v: {4'b0011, 1'b0, 4'(r)}, mr: 1'b1, ld: 1'b0});
            q.push_back('{v: {4'b0001, r == ROWS - 1, 4'(r)}, mr: 1'b1, ld: 1'b0});
        end
        start = 1'b0; stop = 1'b0; step = use_step; frame_tick = use_tick; mem_ready = 1'b1;
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            step = 1'b0; frame_tick = 1'b0; stop = 1'b0;
            chk({tag, "/trace"}, 32'(obs_v()), 32'(q[k].v));
            chk({tag, "/count_hold"}, 32'(gen_count), gc);
            if (abort_row >= 0 && q[k].v[7] && int'(q[k].v[3:0]) == abort_row) begin
                #2 rst = 1'b1;
                #1;
                gc = 0;
                cont = 1'b0;
                chk({tag, "/rst_strobes"}, 32'(obs_v()), 32'h0);
                chk({tag, "/rst_count"}, 32'(gen_count), 32'h0);
                chk({tag, "/rst_cont"}, 32'(continuous), 32'h0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            mem_ready = q[k].mr;
            if (q[k].ld && int'(q[k].v[3:0]) == stop_row) begin
                stop = 1'b1;
                cont = 1'b0;
            end
            if (noise) begin
                step = 1'($urandom_range(0, 1));
                frame_tick = 1'($urandom_range(0, 1));
            end
        end
        gc = (gc + 1) % 65536;
        @(negedge clk);
        step = 1'b0; frame_tick = 1'b0; mem_ready = 1'b1;
        check_idle({tag, "/end"});
    endtask

    initial begin
        for (int r = 0; r < ROWS; r++) st[r] = 0;
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        idle(5, "post_reset", 1'b1);

        run_gen(1'b1, 1'b0, 1'b0, -1, -1, "single");

        st[3] = 5;
        run_gen(1'b1, 1'b0, 1'b0, -1, -1, "stall");
        st[3] = 0;

        start = 1'b1; cont = 1'b1;
        idle(3, "armed", 1'b0);
        for (int g = 0; g < 3; g++) begin
            idle(36, "gap", 1'b0);
            run_gen(1'b0, 1'b1, 1'b0, (g == 2) ? 7 : -1, -1, "tick");
        end
        idle(3, "stopped", 1'b0);
        idle(1, "tick4", 1'b1);
        idle(5, "tick4_ignored", 1'b0);

        start = 1'b1; stop = 1'b1;
        idle(2, "start_stop", 1'b0);

        start = 1'b1; cont = 1'b1;
        idle(1, "arm2", 1'b0);
        run_gen(1'b1, 1'b1, 1'b0, -1, -1, "step_tick");
        stop = 1'b1; cont = 1'b0;
        idle(2, "disarm", 1'b0);

        for (int n = 0; n < 3; n++) begin
            for (int r = 0; r < ROWS; r++) st[r] = int'($urandom_range(0, 2));
            run_gen(1'b1, 1'b0, 1'b1, -1, -1, "noise");
        end
        for (int r = 0; r < ROWS; r++) st[r] = 0;

        run_gen(1'b1, 1'b0, 1'b0, -1, 9, "abort");
        idle(4, "after_rst", 1'b1);
        run_gen(1'b1, 1'b0, 1'b0, -1, -1, "restart");

        for (int g = 1; g <= 16; g++) begin
            int t;
            @(negedge clk);
            step2 = 1'b1;
            @(negedge clk);
            step2 = 1'b0;
            t = 0;
            while (!gd2 && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("wrap_done", 32'(gd2), 32'h1);
            @(negedge clk);
            chk("wrap_count", 32'(gc2), g % 16);
            chk("wrap_idle", 32'(busy2), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
